// File: rtl/booth4_ctrl.sv
// Control sequencer for a radix-4 Booth multiplier datapath.
// It drives the load, recode/add, shift-by-2 and unload strobes c0..c7 for WIDTH/2 iterations.
module booth4_ctrl #(
    parameter  int WIDTH = 8,
    localparam int ITER  = WIDTH / 2,
    localparam int CNT_W = $clog2(ITER) + 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] q_bits,
    output logic       c0,
    output logic       c1,
    output logic       c2,
    output logic       c3,
    output logic       c4,
    output logic       sel_2m,
    output logic       c5,
    output logic       c6,
    output logic       c7,
    output logic       busy,
    output logic       done
);

    typedef enum logic [3:0] {
        IDLE,
        LOAD_Q,
        LOAD_M,
        DECODE,
        ADD,
        SHIFT,
        OUT_A,
        OUT_Q,
        DONE
    } state_t;

    typedef struct packed {
        logic nz;
        logic sub;
        logic two;
    } op_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    op_t              op;
    op_t              op_nx;

    // Booth digit for {q[1],q[0],q[-1]}: nz marks a nonzero digit, sub a negative one, two a magnitude of 2.
    function automatic op_t recode(input logic [2:0] qb);
        op_t r;
        r = '0;
        case (qb)
            3'b001, 3'b010: r.nz = 1'b1;
            3'b011: begin
                r.nz  = 1'b1;
                r.two = 1'b1;
            end
            3'b100: begin
                r.nz  = 1'b1;
                r.sub = 1'b1;
                r.two = 1'b1;
            end
            3'b101, 3'b110: begin
                r.nz  = 1'b1;
                r.sub = 1'b1;
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            op    <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            op    <= op_nx;
        end
    end

    // Strobes depend only on state and op, so they are stable for the whole cycle.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        op_nx    = op;
        c0       = 1'b0;
        c1       = 1'b0;
        c2       = 1'b0;
        c3       = 1'b0;
        c4       = 1'b0;
        sel_2m   = 1'b0;
        c5       = 1'b0;
        c6       = 1'b0;
        c7       = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = LOAD_Q;
            end
            LOAD_Q: begin
                c0       = 1'b1;
                c1       = 1'b1;
                busy     = 1'b1;
                cnt_nx   = '0;
                state_nx = LOAD_M;
            end
            LOAD_M: begin
                c2       = 1'b1;
                busy     = 1'b1;
                state_nx = DECODE;
            end
            DECODE: begin
                busy     = 1'b1;
                op_nx    = recode(q_bits);
                state_nx = op_nx.nz ? ADD : SHIFT;
            end
            ADD: begin
                c3       = 1'b1;
                c4       = op.sub;
                sel_2m   = op.two;
                busy     = 1'b1;
                state_nx = SHIFT;
            end
            SHIFT: begin
                c5       = 1'b1;
                busy     = 1'b1;
                cnt_nx   = cnt + CNT_W'(1);
                state_nx = (cnt == LAST) ? OUT_A : DECODE;
            end
            OUT_A: begin
                c6       = 1'b1;
                busy     = 1'b1;
                state_nx = OUT_Q;
            end
            OUT_Q: begin
                c7       = 1'b1;
                busy     = 1'b1;
                state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                busy     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_booth4_ctrl.sv
// Scoreboard bench for booth4_ctrl: a digit-arithmetic reference model queues the
// expected per-cycle strobe vector and a negedge monitor pops and compares it.
module tb_booth4_ctrl;
    localparam int WIDTH = 8;
    localparam int ITER  = WIDTH / 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] q_bits;
    logic       c0, c1, c2, c3, c4, sel_2m, c5, c6, c7, busy, done;

    booth4_ctrl #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .start(start), .q_bits(q_bits),
        .c0(c0), .c1(c1), .c2(c2), .c3(c3), .c4(c4), .sel_2m(sel_2m),
        .c5(c5), .c6(c6), .c7(c7), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef logic [2:0] qv_t [ITER];

    // Vector layout: {c0,c1,c2,c3,c4,sel_2m,c5,c6,c7,busy,done}
    localparam logic [10:0] V_LQ  = 11'b11000000010;
    localparam logic [10:0] V_LM  = 11'b00100000010;
    localparam logic [10:0] V_DEC = 11'b00000000010;
    localparam logic [10:0] V_ADD = 11'b00010000010;
    localparam logic [10:0] V_SH  = 11'b00000010010;
    localparam logic [10:0] V_OA  = 11'b00000001010;
    localparam logic [10:0] V_OQ  = 11'b00000000110;
    localparam logic [10:0] V_DN  = 11'b00000000011;

    logic [10:0] sb[$];
    int n_checks = 0;
    int n_fail   = 0;
    qv_t qs;

    function automatic logic [10:0] outv();
        return {c0, c1, c2, c3, c4, sel_2m, c5, c6, c7, busy, done};
    endfunction

    task automatic check(input string name, input logic [10:0] got, input logic [10:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%b required=%b", name, $time, got, exp);
        end
    endtask

    // Reference: each Booth digit d = -2*q1 + q0 + q-1 costs DECODE+SHIFT, plus an ADD when d != 0.
    task automatic push_model(input qv_t q, output int lat);
        logic [10:0] a;
        int d;
        lat = 5;
        sb.push_back('0);
        sb.push_back(V_LQ);
        sb.push_back(V_LM);
        for (int i = 0; i < ITER; i++) begin
            d = -2 * int'(q[i][2]) + int'(q[i][1]) + int'(q[i][0]);
            sb.push_back(V_DEC);
            if (d != 0) begin
                a    = V_ADD;
                a[6] = (d < 0);
                a[5] = (d == 2 || d == -2);
                sb.push_back(a);
                lat += 3;
            end else begin
                lat += 2;
            end
            sb.push_back(V_SH);
        end
        sb.push_back(V_OA);
        sb.push_back(V_OQ);
        sb.push_back(V_DN);
    endtask

    always @(negedge clk) begin : monitor
        logic [10:0] e;
        e = (sb.size() > 0) ? sb.pop_front() : 11'b0;
        check("trace", outv(), e);
    end

    // Called at posedge+2 of the cycle in which start should be sampled.
    task automatic run_op(input qv_t q, input bit pulse, input int abort_shift, input bit keep_start);
        int lat, k, nsh, t_lq;
        bit fin;
        push_model(q, lat);
        start  = 1'b1;
        q_bits = q[0];
        k      = 0;
        nsh    = 0;
        t_lq   = -1;
        fin    = 1'b0;
        for (int cyc = 1; cyc <= 40 && !fin; cyc++) begin
            @(posedge clk);
            #2;
            if (!keep_start && busy) start = 1'b0;
            if (c1) t_lq = cyc;
            if (c5) begin
                nsh++;
                k++;
                q_bits = (k < ITER) ? q[k] : 3'($urandom);
                if (nsh == abort_shift) begin
                    reset = 1'b1;
                    start = 1'b0;
                    #1;
                    check("abort_async_zero", outv(), '0);
                    sb.delete();
                    @(posedge clk);
                    #2;
                    reset = 1'b0;
                    fin   = 1'b1;
                end
            end else if (c3) begin
                q_bits = 3'($urandom);
                if (pulse) start = 1'b1;
            end
            if (!fin && done) begin
                fin = 1'b1;
                n_checks++;
                if (cyc - t_lq + 1 != lat) begin
                    n_fail++;
                    $display("FAIL latency got=%0d required=%0d", cyc - t_lq + 1, lat);
                end
            end
        end
        if (!fin) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout no done within 40 cycles");
        end
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b1;
        q_bits = 3'b000;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;

        qs = '{3'b000, 3'b000, 3'b000, 3'b000};
        run_op(qs, 1'b0, 0, 1'b0);

        @(posedge clk); #2;
        qs = '{3'b110, 3'b111, 3'b111, 3'b111};
        run_op(qs, 1'b0, 0, 1'b0);

        @(posedge clk); #2;
        qs = '{3'b011, 3'b100, 3'b001, 3'b101};
        run_op(qs, 1'b1, 0, 1'b0);

        @(posedge clk); #2;
        qs = '{3'b010, 3'b000, 3'b110, 3'b011};
        run_op(qs, 1'b0, 2, 1'b0);

        @(posedge clk); #2;
        qs = '{3'b001, 3'b100, 3'b111, 3'b010};
        run_op(qs, 1'b0, 0, 1'b0);

        @(posedge clk); #2;
        qs = '{3'b101, 3'b000, 3'b011, 3'b110};
        run_op(qs, 1'b0, 0, 1'b1);
        qs = '{3'b100, 3'b001, 3'b000, 3'b111};
        run_op(qs, 1'b0, 0, 1'b0);

        for (int n = 0; n < 8; n++) begin
            @(posedge clk); #2;
            for (int i = 0; i < ITER; i++) qs[i] = 3'($urandom);
            run_op(qs, 1'($urandom), 0, 1'b0);
        end

        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got=%0d required=0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
